// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between the pipeline's IF/MEM stages, the arbiter and the unified memory.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 19
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ready;
  logic [DATA_W-1:0] if_rdata;
  logic              if_stall;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ready;
  logic [DATA_W-1:0] d_rdata;
  logic              d_stall;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_ready, if_rdata, if_stall, d_ready, d_rdata, d_stall,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_ready, if_rdata, if_stall, d_ready, d_rdata, d_stall,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and data access, data first.
// Define MEM_ARB_STARVE_GUARD_EN to force an IF grant after STARVE_MAX back-to-back data grants.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned DATA_W     = 19,
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             reset,
  mem_port_arbiter_if.slave bus
);

  localparam logic [3:0] LatM1     = 4'(MEM_LAT - 1);
  localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

  if (MEM_LAT < 1 || MEM_LAT > 15 || STARVE_MAX > 15) begin : gen_param_err
    $error("mem_port_arbiter: MEM_LAT must be 1..15 and STARVE_MAX at most 15");
  end

  typedef enum logic [1:0] {StIdle, StBusyIf, StBusyD} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic              grant_if, grant_d, force_if;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              if_ready, d_ready;
  logic [DATA_W-1:0] if_rdata, d_rdata;

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic [3:0] starve_q, starve_d;

  // Counts data grants that bypassed a waiting fetch; saturates rather than wrapping.
  always_comb begin
    starve_d = starve_q;
    if (grant_if) begin
      starve_d = '0;
    end else if (grant_d) begin
      if (!bus.if_req) begin
        starve_d = '0;
      end else if (starve_q != 4'hf) begin
        starve_d = starve_q + 4'd1;
      end
    end
  end

  assign force_if = bus.if_req && (starve_q >= StarveMax);

  always_ff @(posedge clk) begin
    if (!reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign force_if = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    grant_if   = 1'b0;
    grant_d    = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    if_ready   = 1'b0;
    d_ready    = 1'b0;
    if_rdata   = if_rdata_q;
    d_rdata    = d_rdata_q;

    // Nothing issues or completes while reset is held; the flops clear at the edge.
    if (reset) begin
      case (state_q)
        StIdle: begin
          if (bus.d_req && !force_if) begin
            grant_d   = 1'b1;
            mem_en    = 1'b1;
            mem_we    = bus.d_we;
            mem_addr  = bus.d_addr;
            mem_wdata = bus.d_wdata;
            we_d      = bus.d_we;
            cnt_d     = LatM1;
            state_d   = StBusyD;
          end else if (bus.if_req) begin
            grant_if  = 1'b1;
            mem_en    = 1'b1;
            mem_addr  = bus.if_addr;
            we_d      = 1'b0;
            cnt_d     = LatM1;
            state_d   = StBusyIf;
          end
        end
        StBusyIf: begin
          if (cnt_q == 4'd0) begin
            if_ready   = 1'b1;
            if_rdata   = bus.mem_rdata;
            if_rdata_d = bus.mem_rdata;
            state_d    = StIdle;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        StBusyD: begin
          if (cnt_q == 4'd0) begin
            d_ready = 1'b1;
            // A write acknowledge leaves the last read word in place.
            if (!we_q) begin
              d_rdata   = bus.mem_rdata;
              d_rdata_d = bus.mem_rdata;
            end
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign bus.mem_en    = mem_en;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.if_ready  = if_ready;
  assign bus.if_rdata  = if_rdata;
  assign bus.d_ready   = d_ready;
  assign bus.d_rdata   = d_rdata;
  assign bus.if_stall  = reset & bus.if_req & ~if_ready;
  assign bus.d_stall   = reset & bus.d_req & ~d_ready;

endmodule
